// File: rtl/pipe_reg_chain_pkg.sv
// rtl/pipe_reg_chain_pkg.sv - shared constants and helpers for the elastic register chain
package pipe_reg_chain_pkg;

  // Deepest chain the DSP operand paths are built with
  localparam int MAX_DEPTH = 16;

  // Occupancy counter width: enough bits for 0..depth, never narrower than 1
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// rtl/pipe_reg_chain_stage.sv - one data+valid register of the elastic chain
module pipe_reg_chain_stage #(
  parameter int               WIDTH     = 18,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Flush drops the valid bit only; data loads just when a valid word arrives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - DEPTH-stage elastic pipeline register chain with bubble collapsing
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int               WIDTH     = 18,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              d,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign out       = d;
    assign out_valid = in_valid & ~clr;
    assign in_ready  = out_ready & ~clr;
    assign occupancy = '0;
  end else begin : g_chain
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic             adv_carry;

    // Advance chain runs output-to-input: an empty stage always moves, a full one only if its successor does
    always_comb begin
      adv_carry = out_ready;
      adv       = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        adv_carry = ~valid_q[i] | adv_carry;
        adv[i]    = adv_carry;
      end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             stg_valid;
      logic [WIDTH-1:0] stg_data;

      if (i == 0) begin : g_head
        assign stg_valid = in_valid;
        assign stg_data  = d;
      end else begin : g_body
        assign stg_valid = valid_q[i-1];
        assign stg_data  = data_q[i-1];
      end

      pipe_reg_chain_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .adv      (adv[i]),
        .in_valid (stg_valid),
        .in_data  (stg_data),
        .valid    (valid_q[i]),
        .data     (data_q[i])
      );
    end

    assign in_ready  = adv[0] & ~clr;
    assign out_valid = valid_q[DEPTH-1] & ~clr;
    assign out       = data_q[DEPTH-1];

    // Occupancy is a pure popcount of the stage valid bits
    always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
        occupancy = occupancy + OCC_W'(valid_q[i]);
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - self-checking bench for pipe_reg_chain (DEPTH=3 and DEPTH=0)
module tb_pipe_reg_chain;

  typedef struct {
    logic        iv;
    logic [17:0] d;
    logic        ordy;
    logic        clr;
    logic        e_ir;
    logic        e_ov;
    logic [17:0] e_out;
    logic [1:0]  e_occ;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] d;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out;
  logic [1:0]  occupancy;

  logic        b_clr;
  logic        b_iv;
  logic        b_ir;
  logic [17:0] b_d;
  logic        b_ov;
  logic        b_or;
  logic [17:0] b_out;
  logic [0:0]  b_occ;

  int          checks   = 0;
  int          failures = 0;
  logic        mon_en   = 1'b0;
  logic [17:0] sb [$];
  vec_t        vt [$];

  always #5 clk = ~clk;

  pipe_reg_chain #(
    .WIDTH     (18),
    .DEPTH     (3),
    .RESET_VAL (18'h155)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .occupancy (occupancy)
  );

  pipe_reg_chain #(
    .WIDTH     (18),
    .DEPTH     (0),
    .RESET_VAL (18'h155)
  ) dut_bypass (
    .clk       (clk),
    .rst       (rst),
    .clr       (b_clr),
    .in_valid  (b_iv),
    .in_ready  (b_ir),
    .d         (b_d),
    .out_valid (b_ov),
    .out_ready (b_or),
    .out       (b_out),
    .occupancy (b_occ)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [17:0] dd, input logic ordy, input logic cl,
                     input logic e_ir, input logic e_ov, input logic [17:0] e_out, input logic [1:0] e_occ);
    vec_t v;
    v.iv = iv; v.d = dd; v.ordy = ordy; v.clr = cl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_out = e_out; v.e_occ = e_occ;
    vt.push_back(v);
  endtask

  // Scoreboard: words enter on an input handshake, leave in order on an output handshake
  always @(negedge clk) begin
    logic [17:0] exp_word;
    logic        exp_ir;
    if (!rst) begin
      sb.delete();
    end else if (mon_en) begin
      exp_ir = !clr && ((sb.size() < 3) || out_ready);
      check("sb_occupancy", 32'(occupancy), 32'(sb.size()));
      check("sb_in_ready", 32'(in_ready), 32'(exp_ir));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual=%0h expected=no_output t=%0t", out, $time);
        end else begin
          exp_word = sb.pop_front();
          check("sb_data", 32'(out), 32'(exp_word));
        end
      end
      if (clr) sb.delete();
      else if (in_valid && in_ready) sb.push_back(d);
    end
  end

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; d = '0; out_ready = 1'b0;
    b_clr = 1'b0; b_iv = 1'b0; b_d = '0; b_or = 1'b0;

    // streaming 1..4, drain
    add(1'b1, 18'h001, 1'b1, 1'b0, 1'b1, 1'b0, 18'h155, 2'd0);
    add(1'b1, 18'h002, 1'b1, 1'b0, 1'b1, 1'b0, 18'h155, 2'd1);
    add(1'b1, 18'h003, 1'b1, 1'b0, 1'b1, 1'b0, 18'h155, 2'd2);
    add(1'b1, 18'h004, 1'b1, 1'b0, 1'b1, 1'b1, 18'h001, 2'd3);
    add(1'b0, 18'h000, 1'b1, 1'b0, 1'b1, 1'b1, 18'h002, 2'd3);
    add(1'b0, 18'h000, 1'b1, 1'b0, 1'b1, 1'b1, 18'h003, 2'd2);
    add(1'b0, 18'h000, 1'b1, 1'b0, 1'b1, 1'b1, 18'h004, 2'd1);
    add(1'b0, 18'h000, 1'b1, 1'b0, 1'b1, 1'b0, 18'h004, 2'd0);
    // backpressure: 5,6,7 fill, 8 and 9 wait upstream
    add(1'b1, 18'h005, 1'b0, 1'b0, 1'b1, 1'b0, 18'h004, 2'd0);
    add(1'b1, 18'h006, 1'b0, 1'b0, 1'b1, 1'b0, 18'h004, 2'd1);
    add(1'b1, 18'h007, 1'b0, 1'b0, 1'b1, 1'b0, 18'h004, 2'd2);
    add(1'b1, 18'h008, 1'b0, 1'b0, 1'b0, 1'b1, 18'h005, 2'd3);
    add(1'b1, 18'h008, 1'b0, 1'b0, 1'b0, 1'b1, 18'h005, 2'd3);
    add(1'b1, 18'h008, 1'b1, 1'b0, 1'b1, 1'b1, 18'h005, 2'd3);
    add(1'b1, 18'h009, 1'b1, 1'b0, 1'b1, 1'b1, 18'h006, 2'd3);
    add(1'b0, 18'h000, 1'b1, 1'b0, 1'b1, 1'b1, 18'h007, 2'd3);
    add(1'b0, 18'h000, 1'b1, 1'b0, 1'b1, 1'b1, 18'h008, 2'd2);
    add(1'b0, 18'h000, 1'b1, 1'b0, 1'b1, 1'b1, 18'h009, 2'd1);
    add(1'b0, 18'h000, 1'b0, 1'b0, 1'b1, 1'b0, 18'h009, 2'd0);
    // bubble collapse: A, gap, B under stall
    add(1'b1, 18'h111, 1'b0, 1'b0, 1'b1, 1'b0, 18'h009, 2'd0);
    add(1'b0, 18'h000, 1'b0, 1'b0, 1'b1, 1'b0, 18'h009, 2'd1);
    add(1'b1, 18'h222, 1'b0, 1'b0, 1'b1, 1'b0, 18'h009, 2'd1);
    add(1'b0, 18'h000, 1'b0, 1'b0, 1'b1, 1'b1, 18'h111, 2'd2);
    add(1'b0, 18'h000, 1'b0, 1'b0, 1'b1, 1'b1, 18'h111, 2'd2);
    add(1'b0, 18'h000, 1'b1, 1'b0, 1'b1, 1'b1, 18'h111, 2'd2);
    add(1'b0, 18'h000, 1'b1, 1'b0, 1'b1, 1'b1, 18'h222, 2'd1);
    add(1'b0, 18'h000, 1'b0, 1'b0, 1'b1, 1'b0, 18'h222, 2'd0);
    // flush with a full chain, then flush while empty
    add(1'b1, 18'h010, 1'b0, 1'b0, 1'b1, 1'b0, 18'h222, 2'd0);
    add(1'b1, 18'h011, 1'b0, 1'b0, 1'b1, 1'b0, 18'h222, 2'd1);
    add(1'b1, 18'h012, 1'b0, 1'b0, 1'b1, 1'b0, 18'h222, 2'd2);
    add(1'b1, 18'h013, 1'b1, 1'b1, 1'b0, 1'b0, 18'h010, 2'd3);
    add(1'b0, 18'h000, 1'b1, 1'b0, 1'b1, 1'b0, 18'h010, 2'd0);
    add(1'b1, 18'h014, 1'b1, 1'b1, 1'b0, 1'b0, 18'h010, 2'd0);
    add(1'b0, 18'h000, 1'b1, 1'b0, 1'b1, 1'b0, 18'h010, 2'd0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 32'(out), 32'h155);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_occupancy", 32'(occupancy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // bypass checks, some while reset is held low
    for (int i = 0; i < 10; i++) begin
      b_d   = 18'($urandom);
      b_iv  = 1'($urandom);
      b_or  = 1'($urandom);
      b_clr = (i % 3 == 0);
      if (i == 5) rst = 1'b1;
      #1;
      check("bypass_out", 32'(b_out), 32'(b_d));
      check("bypass_out_valid", 32'(b_ov), 32'(b_iv & ~b_clr));
      check("bypass_in_ready", 32'(b_ir), 32'(b_or & ~b_clr));
      check("bypass_occupancy", 32'(b_occ), 32'd0);
    end
    b_clr = 1'b1; b_iv = 1'b1; b_or = 1'b1;
    #1;
    check("bypass_clr_out_valid", 32'(b_ov), 32'd0);
    check("bypass_clr_in_ready", 32'(b_ir), 32'd0);

    rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    mon_en = 1'b1;

    foreach (vt[k]) begin
      @(posedge clk);
      #1;
      in_valid = vt[k].iv; d = vt[k].d; out_ready = vt[k].ordy; clr = vt[k].clr;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(vt[k].e_ir));
      check($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(vt[k].e_ov));
      check($sformatf("vec%0d_out", k), 32'(out), 32'(vt[k].e_out));
      check($sformatf("vec%0d_occupancy", k), 32'(occupancy), 32'(vt[k].e_occ));
    end

    // reset mid-stream discards in-flight words immediately
    @(posedge clk); #1 in_valid = 1'b1; d = 18'h021; out_ready = 1'b0; clr = 1'b0;
    @(posedge clk); #1 d = 18'h022;
    @(posedge clk); #1 in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_out", 32'(out), 32'h155);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_occupancy", 32'(occupancy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;

    // latency: accepted at edge n, visible after edge n+2
    @(posedge clk); #1 in_valid = 1'b1; d = 18'h030; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    check("latency_early_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("latency_out_valid", 32'(out_valid), 32'd1);
    check("latency_out", 32'(out), 32'h030);
    repeat (3) @(posedge clk);
    #1;
    check("final_occupancy", 32'(occupancy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
